// File: rtl/conway_gen_scheduler_pkg.sv
// conway_gen_scheduler_pkg: shared FSM state type, host register map and bit positions
// for the Conway generation scheduler.
package conway_gen_scheduler_pkg;
    typedef enum logic [2:0] {IDLE, START, RUN, WAIT_VB, SWAP} sched_state_t;

    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_GEN_LIMIT = 3'd1;
    localparam logic [2:0] REG_GEN_COUNT = 3'd2;
    localparam logic [2:0] REG_STATUS    = 3'd3;
    localparam logic [2:0] REG_SEED_ADDR = 3'd4;
    localparam logic [2:0] REG_SEED_LO   = 3'd5;
    localparam logic [2:0] REG_SEED_HI   = 3'd6;

    localparam int CTRL_RUN       = 0;
    localparam int CTRL_STEP      = 1;
    localparam int CTRL_SEED_MODE = 2;
    localparam int CTRL_CLR_GEN   = 3;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DISP     = 1;
    localparam int STAT_STEP     = 2;
    localparam int STAT_SEED_ERR = 3;
endpackage

// File: rtl/conway_gen_scheduler_if.sv
// conway_gen_scheduler_if: host register bus, accelerator handshake, video and seed-write
// signals of the generation scheduler.
interface conway_gen_scheduler_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 20
);
    logic              host_chipselect;
    logic              host_write;
    logic              host_read;
    logic [2:0]        host_address;
    logic [15:0]       host_writedata;
    logic [15:0]       host_readdata;
    logic              accel_start;
    logic              accel_src_sel;
    logic              accel_done;
    logic              vblank;
    logic              display_sel;
    logic              seed_we;
    logic [ADDR_W-1:0] seed_addr;
    logic [DATA_W-1:0] seed_data;

    modport master (
        output host_chipselect, host_write, host_read, host_address, host_writedata,
        output accel_done, vblank,
        input  host_readdata, accel_start, accel_src_sel, display_sel,
        input  seed_we, seed_addr, seed_data
    );

    modport slave (
        input  host_chipselect, host_write, host_read, host_address, host_writedata,
        input  accel_done, vblank,
        output host_readdata, accel_start, accel_src_sel, display_sel,
        output seed_we, seed_addr, seed_data
    );
endinterface

// File: rtl/conway_gen_scheduler_regs.sv
// conway_sched_regs: host register decode and storage, registered readback, step/clr_gen
// pulses and the seed commit path into the displayed grid.
module conway_sched_regs
    import conway_gen_scheduler_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 20,
    parameter int GEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_i,
    input  logic              wr_i,
    input  logic              rd_i,
    input  logic [2:0]        addr_i,
    input  logic [15:0]       wdata_i,
    output logic [15:0]       rdata_o,
    input  logic              idle_i,
    input  logic              disp_i,
    input  logic              start_i,
    input  logic              run_clr_i,
    input  logic [GEN_W-1:0]  gen_count_i,
    output logic              run_o,
    output logic              seed_mode_o,
    output logic              step_pending_o,
    output logic              clr_gen_o,
    output logic [GEN_W-1:0]  gen_limit_o,
    output logic              seed_we_o,
    output logic [ADDR_W-1:0] seed_addr_o,
    output logic [DATA_W-1:0] seed_data_o
);
    logic              run_q, run_d, seed_mode_q, seed_mode_d, step_q, step_d;
    logic              err_q, err_d, we_q, we_d;
    logic [GEN_W-1:0]  limit_q, limit_d;
    logic [ADDR_W-1:0] saddr_q, saddr_d, oaddr_q, oaddr_d;
    logic [15:0]       lo_q, lo_d, rdata_q, rdata_d, rmux;
    logic [DATA_W-1:0] odata_q, odata_d;
    logic              wr, w_ctrl, commit, commit_ok;

    assign wr        = cs_i && wr_i;
    assign w_ctrl    = wr && addr_i == REG_CTRL;
    assign commit    = wr && addr_i == REG_SEED_HI;
    assign commit_ok = commit && idle_i && seed_mode_q;
    assign clr_gen_o = w_ctrl && wdata_i[CTRL_CLR_GEN];

    always_comb begin
        rmux = '0;
        case (addr_i)
            REG_CTRL: begin
                rmux[CTRL_RUN]       = run_q;
                rmux[CTRL_SEED_MODE] = seed_mode_q;
            end
            REG_GEN_LIMIT: rmux = 16'(limit_q);
            REG_GEN_COUNT: rmux = 16'(gen_count_i);
            REG_STATUS: begin
                rmux[STAT_BUSY]     = !idle_i;
                rmux[STAT_DISP]     = disp_i;
                rmux[STAT_STEP]     = step_q;
                rmux[STAT_SEED_ERR] = err_q;
            end
            REG_SEED_ADDR: rmux = 16'(saddr_q);
            REG_SEED_LO:   rmux = lo_q;
            default: ;
        endcase
    end

    // A limit-reached clear at SWAP overrides a host CTRL write in the same cycle.
    always_comb begin
        run_d       = run_clr_i ? 1'b0 : w_ctrl ? wdata_i[CTRL_RUN] : run_q;
        seed_mode_d = w_ctrl ? wdata_i[CTRL_SEED_MODE] : seed_mode_q;
        step_d      = (w_ctrl && wdata_i[CTRL_STEP]) || (step_q && !start_i);
        limit_d     = (wr && addr_i == REG_GEN_LIMIT) ? GEN_W'(wdata_i) : limit_q;
        saddr_d     = (wr && addr_i == REG_SEED_ADDR) ? ADDR_W'(wdata_i) :
                      commit_ok ? saddr_q + ADDR_W'(1) : saddr_q;
        lo_d        = (wr && addr_i == REG_SEED_LO) ? wdata_i : lo_q;
        err_d       = (wr && addr_i == REG_STATUS) ? 1'b0 : (commit && !commit_ok) ? 1'b1 : err_q;
        we_d        = commit_ok;
        oaddr_d     = commit_ok ? saddr_q : oaddr_q;
        odata_d     = commit_ok ? DATA_W'({wdata_i[3:0], lo_q}) : odata_q;
        rdata_d     = (cs_i && rd_i) ? rmux : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q       <= 1'b0;
            seed_mode_q <= 1'b0;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            limit_q     <= '0;
            saddr_q     <= '0;
            oaddr_q     <= '0;
            lo_q        <= '0;
            odata_q     <= '0;
            rdata_q     <= '0;
        end else begin
            run_q       <= run_d;
            seed_mode_q <= seed_mode_d;
            step_q      <= step_d;
            err_q       <= err_d;
            we_q        <= we_d;
            limit_q     <= limit_d;
            saddr_q     <= saddr_d;
            oaddr_q     <= oaddr_d;
            lo_q        <= lo_d;
            odata_q     <= odata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign run_o          = run_q;
    assign seed_mode_o    = seed_mode_q;
    assign step_pending_o = step_q;
    assign gen_limit_o    = limit_q;
    assign seed_we_o      = we_q;
    assign seed_addr_o    = oaddr_q;
    assign seed_data_o    = odata_q;
    assign rdata_o        = rdata_q;
endmodule

// File: rtl/conway_gen_scheduler.sv
// conway_gen_scheduler: per-generation sequencer for the Conway accelerator; starts one pass
// per generation and swaps the displayed ping-pong buffer only inside vblank.
module conway_gen_scheduler
    import conway_gen_scheduler_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 20,
    parameter int GEN_W  = 16
) (
    input logic             clk,
    input logic             reset,
    conway_gen_scheduler_if.slave bus
);
    sched_state_t     state_q, state_d;
    logic             disp_q, disp_d, src_q, src_d;
    logic [GEN_W-1:0] gen_q, gen_d, gen_inc, gen_limit;
    logic             run, seed_mode, step_pending, clr_gen, limit_hit, idle;

    conway_sched_regs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GEN_W(GEN_W)) u_regs (
        .clk            (clk),
        .reset          (reset),
        .cs_i           (bus.host_chipselect),
        .wr_i           (bus.host_write),
        .rd_i           (bus.host_read),
        .addr_i         (bus.host_address),
        .wdata_i        (bus.host_writedata),
        .rdata_o        (bus.host_readdata),
        .idle_i         (idle),
        .disp_i         (disp_q),
        .start_i        (state_q == START),
        .run_clr_i      (limit_hit),
        .gen_count_i    (gen_q),
        .run_o          (run),
        .seed_mode_o    (seed_mode),
        .step_pending_o (step_pending),
        .clr_gen_o      (clr_gen),
        .gen_limit_o    (gen_limit),
        .seed_we_o      (bus.seed_we),
        .seed_addr_o    (bus.seed_addr),
        .seed_data_o    (bus.seed_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            disp_q  <= 1'b0;
            src_q   <= 1'b0;
            gen_q   <= '0;
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
            src_q   <= src_d;
            gen_q   <= gen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (!seed_mode && (run || step_pending)) ? START : IDLE;
            START:   state_d = RUN;
            RUN:     state_d = bus.accel_done ? WAIT_VB : RUN;
            WAIT_VB: state_d = bus.vblank ? SWAP : WAIT_VB;
            SWAP:    state_d = (run && !limit_hit) ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The source buffer is captured on entry to START so it is already valid with accel_start.
    assign gen_inc   = gen_q + GEN_W'(1);
    assign limit_hit = state_q == SWAP && gen_limit != '0 && gen_inc >= gen_limit;

    always_comb begin
        disp_d = (state_q == SWAP) ? !disp_q : disp_q;
        gen_d  = (state_q == SWAP) ? gen_inc : (idle && clr_gen) ? '0 : gen_q;
        src_d  = (state_d == START) ? disp_d : src_q;
    end

    always_comb begin
        idle              = state_q == IDLE;
        bus.accel_start   = state_q == START;
        bus.accel_src_sel = src_q;
        bus.display_sel   = disp_q;
    end
endmodule

// File: tb/tb_conway_gen_scheduler.sv
// tb_conway_gen_scheduler: directed scenario tests of the generation scheduler with
// hand-computed expectations.
module tb_conway_gen_scheduler;
    import conway_gen_scheduler_pkg::*;

    logic clk, reset;
    int checks, errors, starts, we_cnt;
    logic src_log[$];
    logic [15:0] we_addr, rd;
    logic [19:0] we_data;

    conway_gen_scheduler_if bus ();
    conway_gen_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.accel_start) begin
            starts++;
            src_log.push_back(bus.accel_src_sel);
        end
        if (bus.seed_we) begin
            we_cnt++;
            we_addr = bus.seed_addr;
            we_data = bus.seed_data;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic host_wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.host_chipselect = 1'b1;
        bus.host_write = 1'b1;
        bus.host_address = a;
        bus.host_writedata = d;
        @(negedge clk);
        bus.host_chipselect = 1'b0;
        bus.host_write = 1'b0;
    endtask

    task automatic host_rd(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.host_chipselect = 1'b1;
        bus.host_read = 1'b1;
        bus.host_address = a;
        @(negedge clk);
        bus.host_chipselect = 1'b0;
        bus.host_read = 1'b0;
        d = bus.host_readdata;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.accel_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.accel_start !== 1'b1) begin
            errors++;
            $display("FAIL %s start_timeout got=%b want=1", tag, bus.accel_start);
        end
    endtask

    task automatic pulse_done();
        @(negedge clk);
        bus.accel_done = 1'b1;
        @(negedge clk);
        bus.accel_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            host_rd(3'(i), rd);
            checks++;
            if (rd !== 16'h0) begin errors++; $display("FAIL reset_reg%0d got=%h want=0000", i, rd); end
        end
        checks++;
        if (bus.display_sel !== 1'b0) begin errors++; $display("FAIL reset_disp got=%b want=0", bus.display_sel); end
        checks++;
        if (bus.accel_src_sel !== 1'b0 || bus.seed_we !== 1'b0) begin
            errors++; $display("FAIL reset_outs src=%b we=%b want=0,0", bus.accel_src_sel, bus.seed_we);
        end
        checks++;
        if (starts !== 0) begin errors++; $display("FAIL reset_nostart got=%0d want=0", starts); end
    endtask

    task automatic test_step();
        int s0;
        s0 = starts;
        host_wr(REG_CTRL, 16'h0002);
        wait_start("step");
        checks++;
        if (bus.accel_src_sel !== 1'b0) begin errors++; $display("FAIL step_src got=%b want=0", bus.accel_src_sel); end
        repeat (10) @(negedge clk);
        bus.accel_done = 1'b1;
        @(negedge clk);
        bus.accel_done = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.display_sel !== 1'b0) begin errors++; $display("FAIL step_disp_novb got=%b want=0", bus.display_sel); end
        bus.vblank = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.display_sel !== 1'b0) begin errors++; $display("FAIL step_disp_swapcyc got=%b want=0", bus.display_sel); end
        @(negedge clk);
        checks++;
        if (bus.display_sel !== 1'b1) begin errors++; $display("FAIL step_disp_flip got=%b want=1", bus.display_sel); end
        bus.vblank = 1'b0;
        host_rd(REG_GEN_COUNT, rd);
        checks++;
        if (rd !== 16'h0001) begin errors++; $display("FAIL step_gen got=%h want=0001", rd); end
        host_rd(REG_STATUS, rd);
        checks++;
        if (rd !== 16'h0002) begin errors++; $display("FAIL step_status got=%h want=0002", rd); end
        host_rd(REG_CTRL, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL step_ctrl got=%h want=0000", rd); end
        checks++;
        if (starts - s0 !== 1) begin errors++; $display("FAIL step_count got=%0d want=1", starts - s0); end
    endtask

    task automatic test_run_limit();
        int s0, b, cnt;
        do_reset();
        s0 = starts;
        b = src_log.size();
        cnt = 0;
        host_wr(REG_GEN_LIMIT, 16'd3);
        host_wr(REG_CTRL, 16'h0001);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            bus.accel_done = (cnt == 1);
            if (cnt > 0) cnt--;
            if (bus.accel_start) cnt = 3;
            bus.vblank = (c % 16) >= 12;
        end
        bus.vblank = 1'b0;
        bus.accel_done = 1'b0;
        checks++;
        if (starts - s0 !== 3) begin errors++; $display("FAIL run_starts got=%0d want=3", starts - s0); end
        checks++;
        if (src_log.size() < b + 3 || src_log[b] !== 1'b0 || src_log[b+1] !== 1'b1 || src_log[b+2] !== 1'b0) begin
            errors++; $display("FAIL run_src_seq got_entries=%0d want=0,1,0", src_log.size() - b);
        end
        host_rd(REG_CTRL, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL run_cleared got=%h want=0000", rd); end
        host_rd(REG_GEN_COUNT, rd);
        checks++;
        if (rd !== 16'h0003) begin errors++; $display("FAIL run_gen got=%h want=0003", rd); end
        host_rd(REG_STATUS, rd);
        checks++;
        if (rd !== 16'h0002) begin errors++; $display("FAIL run_status got=%h want=0002", rd); end
    endtask

    task automatic test_done_vblank();
        int s0;
        s0 = starts;
        host_wr(REG_CTRL, 16'h0002);
        wait_start("vb_high");
        bus.vblank = 1'b1;
        repeat (3) @(negedge clk);
        bus.accel_done = 1'b1;
        @(negedge clk);
        bus.accel_done = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.display_sel !== 1'b1) begin errors++; $display("FAIL vbh_early got=%b want=1", bus.display_sel); end
        @(negedge clk);
        checks++;
        if (bus.display_sel !== 1'b0) begin errors++; $display("FAIL vbh_swap got=%b want=0", bus.display_sel); end
        bus.vblank = 1'b0;
        host_wr(REG_CTRL, 16'h0002);
        wait_start("vb_low");
        repeat (3) @(negedge clk);
        pulse_done();
        repeat (8) @(negedge clk);
        checks++;
        if (bus.display_sel !== 1'b0) begin errors++; $display("FAIL vbl_hold got=%b want=0", bus.display_sel); end
        bus.vblank = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.display_sel !== 1'b0) begin errors++; $display("FAIL vbl_early got=%b want=0", bus.display_sel); end
        @(negedge clk);
        checks++;
        if (bus.display_sel !== 1'b1) begin errors++; $display("FAIL vbl_swap got=%b want=1", bus.display_sel); end
        bus.vblank = 1'b0;
        host_wr(REG_CTRL, 16'h0002);
        wait_start("vb_glitch");
        repeat (3) @(negedge clk);
        bus.accel_done = 1'b1;
        bus.vblank = 1'b1;
        @(negedge clk);
        bus.accel_done = 1'b0;
        bus.vblank = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (bus.display_sel !== 1'b1) begin errors++; $display("FAIL glitch_noswap got=%b want=1", bus.display_sel); end
        host_rd(REG_STATUS, rd);
        checks++;
        if (rd !== 16'h0003) begin errors++; $display("FAIL glitch_status got=%h want=0003", rd); end
        bus.vblank = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.display_sel !== 1'b0) begin errors++; $display("FAIL glitch_swap got=%b want=0", bus.display_sel); end
        bus.vblank = 1'b0;
        repeat (3) @(negedge clk);
        pulse_done();
        repeat (3) @(negedge clk);
        host_rd(REG_STATUS, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL idle_done_ignored got=%h want=0000", rd); end
        host_rd(REG_GEN_COUNT, rd);
        checks++;
        if (rd !== 16'h0006) begin errors++; $display("FAIL vb_gen got=%h want=0006", rd); end
        checks++;
        if (starts - s0 !== 3) begin errors++; $display("FAIL vb_starts got=%0d want=3", starts - s0); end
        host_wr(REG_CTRL, 16'h0008);
        host_rd(REG_GEN_COUNT, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL clr_gen got=%h want=0000", rd); end
    endtask

    task automatic test_seed();
        int w0;
        host_wr(REG_CTRL, 16'h0004);
        host_wr(REG_SEED_ADDR, 16'hFFFF);
        host_wr(REG_SEED_LO, 16'h1234);
        w0 = we_cnt;
        host_wr(REG_SEED_HI, 16'h0005);
        @(negedge clk);
        checks++;
        if (we_cnt - w0 !== 1) begin errors++; $display("FAIL seed_we got=%0d want=1", we_cnt - w0); end
        checks++;
        if (we_addr !== 16'hFFFF || we_data !== 20'h51234) begin
            errors++; $display("FAIL seed_word got=%h/%h want=ffff/51234", we_addr, we_data);
        end
        host_rd(REG_SEED_ADDR, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL seed_wrap got=%h want=0000", rd); end
        host_rd(REG_STATUS, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL seed_noerr got=%h want=0000", rd); end
        host_wr(REG_CTRL, 16'h0002);
        wait_start("seed_busy");
        host_wr(REG_CTRL, 16'h0004);
        host_wr(REG_SEED_HI, 16'h0005);
        pulse_done();
        bus.vblank = 1'b1;
        repeat (3) @(negedge clk);
        bus.vblank = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (we_cnt - w0 !== 1) begin errors++; $display("FAIL seed_busy_drop got=%0d want=1", we_cnt - w0); end
        host_rd(REG_STATUS, rd);
        checks++;
        if (rd !== 16'h000A) begin errors++; $display("FAIL seed_err got=%h want=000a", rd); end
        host_wr(REG_STATUS, 16'h0000);
        host_rd(REG_STATUS, rd);
        checks++;
        if (rd !== 16'h0002) begin errors++; $display("FAIL seed_err_clr got=%h want=0002", rd); end
    endtask

    task automatic test_reset_mid_pass();
        int s0;
        host_wr(REG_CTRL, 16'h0002);
        wait_start("mid_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.accel_start !== 1'b0 || bus.display_sel !== 1'b0 || bus.accel_src_sel !== 1'b0 || bus.seed_we !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outs start=%b disp=%b src=%b we=%b want=0,0,0,0",
                     bus.accel_start, bus.display_sel, bus.accel_src_sel, bus.seed_we);
        end
        reset = 1'b0;
        s0 = starts;
        host_rd(REG_STATUS, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL midrst_idle got=%h want=0000", rd); end
        pulse_done();
        repeat (5) @(negedge clk);
        host_rd(REG_STATUS, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL midrst_done_ignored got=%h want=0000", rd); end
        host_rd(REG_GEN_COUNT, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL midrst_gen got=%h want=0000", rd); end
        checks++;
        if (starts !== s0) begin errors++; $display("FAIL midrst_nostart got=%0d want=%0d", starts, s0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        starts = 0;
        we_cnt = 0;
        reset = 1'b1;
        bus.host_chipselect = 1'b0;
        bus.host_write = 1'b0;
        bus.host_read = 1'b0;
        bus.host_address = 3'd0;
        bus.host_writedata = 16'h0;
        bus.accel_done = 1'b0;
        bus.vblank = 1'b0;
        test_reset();
        test_step();
        test_run_limit();
        test_done_vblank();
        test_seed();
        test_reset_mid_pass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
